// File: rtl/mmio_uart_tx_if.sv
// Data-memory-port bundle between the core and the memory-mapped UART transmitter.
interface mmio_uart_tx_if #(
   parameter int unsigned WORD_LEN = 32
);
   logic [WORD_LEN-1:0] d_addr;
   logic                wen;
   logic [WORD_LEN-1:0] wdata;
   logic [WORD_LEN-1:0] rdata;
   logic                hit;

   modport master (output d_addr, output wen, output wdata, input rdata, input hit);
   modport slave  (input d_addr, input wen, input wdata, output rdata, output hit);
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a byte FIFO and a combinational status read port.
// Optional sent/dropped counters at +0x8/+0xC are enabled by defining MMIO_UART_TX_STATS_EN.
module mmio_uart_tx #(
   parameter int unsigned         WORD_LEN     = 32,
   parameter logic [WORD_LEN-1:0] BASE_ADDR    = 'hF000_0000,
   parameter int unsigned         CLKS_PER_BIT = 234,
   parameter int unsigned         FIFO_DEPTH   = 16
) (
   input  logic          clk,
   input  logic          rst,
   mmio_uart_tx_if.slave bus,
   output logic          tx,
   output logic          busy
);
   localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
   localparam int unsigned CntW  = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

   state_e            state_q, state_d;
   logic [BaudW-1:0]  baud_q, baud_d;
   logic [2:0]        bit_q, bit_d;
   logic [7:0]        shift_q, shift_d;
   logic              tx_q, tx_d;
   logic              busy_q, busy_d;
   logic [7:0]        fifo_q [FIFO_DEPTH];
   logic [PtrW-1:0]   wptr_q, rptr_q;
   logic [CntW-1:0]   count_q, count_d;
   logic              ovf_q, ovf_d;

   logic [1:0]  reg_off;
   logic        wr_en, wr_txdata, wr_status;
   logic        full, empty, push, pop, ovf_set;
   logic        baud_last, frame_done;
   logic [31:0] status;
   logic        unused_bits;

   assign bus.hit   = (bus.d_addr[WORD_LEN-1:4] == BASE_ADDR[WORD_LEN-1:4]);
   assign reg_off   = bus.d_addr[3:2];
   assign wr_en     = bus.wen && bus.hit;
   assign wr_txdata = wr_en && (reg_off == 2'd0);
   assign wr_status = wr_en && (reg_off == 2'd1);

   assign full    = (count_q == CntW'(FIFO_DEPTH));
   assign empty   = (count_q == '0);
   assign push    = wr_txdata && !full;
   assign ovf_set = wr_txdata && full;

   assign baud_last = (baud_q == BaudW'(CLKS_PER_BIT - 1));
   assign status    = {16'h0, 8'(count_q), 5'h0, ovf_q, full, busy_q};
   assign unused_bits = ^{bus.d_addr[1:0], bus.wdata[WORD_LEN-1:8]};

   // Transmit FSM; a pop always loads the shift register and drives the start bit at once.
   always_comb begin
      state_d    = state_q;
      baud_d     = baud_q;
      bit_d      = bit_q;
      shift_d    = shift_q;
      tx_d       = tx_q;
      pop        = 1'b0;
      frame_done = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (!empty) begin
               pop     = 1'b1;
               shift_d = fifo_q[rptr_q];
               baud_d  = '0;
               tx_d    = 1'b0;
               state_d = StStart;
            end
         end
         StStart: begin
            baud_d = baud_q + 1'b1;
            if (baud_last) begin
               baud_d  = '0;
               bit_d   = '0;
               tx_d    = shift_q[0];
               state_d = StData;
            end
         end
         StData: begin
            baud_d = baud_q + 1'b1;
            if (baud_last) begin
               baud_d = '0;
               if (bit_q == 3'd7) begin
                  tx_d    = 1'b1;
                  state_d = StStop;
               end else begin
                  bit_d   = bit_q + 1'b1;
                  shift_d = shift_q >> 1;
                  tx_d    = shift_q[1];
               end
            end
         end
         StStop: begin
            baud_d = baud_q + 1'b1;
            if (baud_last) begin
               baud_d     = '0;
               frame_done = 1'b1;
               if (!empty) begin
                  pop     = 1'b1;
                  shift_d = fifo_q[rptr_q];
                  tx_d    = 1'b0;
                  state_d = StStart;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + 1'b1;
      end else if (pop && !push) begin
         count_d = count_q - 1'b1;
      end
      ovf_d = ovf_q;
      if (wr_status && bus.wdata[2]) begin
         ovf_d = 1'b0;
      end
      if (ovf_set) begin
         ovf_d = 1'b1;
      end
      busy_d = (state_d != StIdle) || (count_d != '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         if (push) wptr_q <= wptr_q + 1'b1;
         if (pop)  rptr_q <= rptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_q[wptr_q] <= bus.wdata[7:0];
      end
   end

`ifdef MMIO_UART_TX_STATS_EN
   logic [31:0] sent_q, dropped_q;
   logic        stats_clr;

   assign stats_clr = wr_en && (reg_off == 2'd2);

   // Clear takes priority over a coincident increment.
   always_ff @(posedge clk) begin
      if (rst || stats_clr) begin
         sent_q    <= '0;
         dropped_q <= '0;
      end else begin
         if (frame_done) sent_q    <= sent_q + 1'b1;
         if (ovf_set)    dropped_q <= dropped_q + 1'b1;
      end
   end

   always_comb begin
      bus.rdata = '0;
      if (bus.hit) begin
         case (reg_off)
            2'd1:    bus.rdata = WORD_LEN'(status);
            2'd2:    bus.rdata = WORD_LEN'(sent_q);
            2'd3:    bus.rdata = WORD_LEN'(dropped_q);
            default: bus.rdata = '0;
         endcase
      end
   end
`else
   logic unused_frame_done;
   assign unused_frame_done = frame_done;

   always_comb begin
      bus.rdata = '0;
      if (bus.hit && (reg_off == 2'd1)) begin
         bus.rdata = WORD_LEN'(status);
      end
   end
`endif

   assign tx   = tx_q;
   assign busy = busy_q;
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: directed bus traffic plus a UART line monitor checked against
// a queue of expected bytes.
module tb_mmio_uart_tx;
   localparam logic [31:0] BASE = 32'hF000_0000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic tx, busy;
   int   cyc = 0;
   int   rst_cnt = 0;
   int   n_pass = 0;
   int   n_total = 0;
   int   n_frames = 0;
   logic [7:0] exp_q [$];
   int   start_q [$];

   mmio_uart_tx_if #(.WORD_LEN(32)) bus ();

   mmio_uart_tx #(
      .WORD_LEN    (32),
      .BASE_ADDR   (32'hF000_0000),
      .CLKS_PER_BIT(4),
      .FIFO_DEPTH  (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus),
      .tx  (tx),
      .busy(busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rst) rst_cnt <= rst_cnt + 1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, required %h", name, act, exp);
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] d);
      bus.d_addr = a;
      #1 d = bus.rdata;
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      bus.d_addr = a;
      bus.wdata  = d;
      bus.wen    = 1'b1;
      @(posedge clk);
      #1 bus.wen = 1'b0;
   endtask

   task automatic put(input logic [7:0] d);
      @(negedge clk);
      bus.d_addr = BASE;
      bus.wdata  = {24'h0, d};
      bus.wen    = 1'b1;
   endtask

   task automatic put_end();
      @(posedge clk);
      #1 bus.wen = 1'b0;
   endtask

   // Returns the cycle at which busy was first seen low, or -1 on timeout.
   task automatic wait_idle(input int budget, output int drop);
      drop = -1;
      for (int i = 0; i < budget; i++) begin
         @(posedge clk);
         #1;
         if (!busy) begin
            drop = cyc;
            break;
         end
      end
   endtask

   // Line monitor: decodes each frame by cycle position relative to the start bit.
   initial begin
      int         r0;
      logic [7:0] b;
      logic [7:0] e;
      bit         aborted;
      forever begin
         @(negedge clk);
         if (!rst && tx === 1'b0) begin
            r0 = rst_cnt;
            aborted = 1'b0;
            b = '0;
            start_q.push_back(cyc);
            for (int c = 1; c < 40; c++) begin
               @(negedge clk);
               if (rst_cnt != r0) begin
                  aborted = 1'b1;
                  break;
               end
               if (c == 2) check("start_bit", {31'b0, tx}, 32'h0);
               if (c >= 5 && c <= 33 && (c % 4) == 1) b[(c - 5) / 4] = tx;
               if (c == 37) begin
                  check("stop_bit", {31'b0, tx}, 32'h1);
                  n_frames++;
                  if (exp_q.size() == 0) begin
                     n_total++;
                     $display("FAIL frame: got unexpected byte %h, required no frame", b);
                  end else begin
                     e = exp_q.pop_front();
                     check("frame_byte", {24'h0, b}, {24'h0, e});
                  end
               end
            end
            if (aborted) start_q.delete();
         end
      end
   end

   initial begin
      logic [31:0] d;
      int          n0, drop, f0;
      bus.d_addr = '0;
      bus.wdata  = '0;
      bus.wen    = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Reset state and address decode
      check("reset_tx", {31'b0, tx}, 32'h1);
      check("reset_busy", {31'b0, busy}, 32'h0);
      rd(BASE + 4, d);
      check("reset_status", d, 32'h0);
      bus.d_addr = 32'h0000_1000;
      #1 check("hit_miss", {31'b0, bus.hit}, 32'h0);
      check("rdata_miss", bus.rdata, 32'h0);
      bus.d_addr = 32'hF000_0008;
      #1 check("hit_base8", {31'b0, bus.hit}, 32'h1);

      // Single frame 0x55
      exp_q.push_back(8'h55);
      bus_write(BASE, 32'h55);
      n0 = cyc;
      check("t1_tx_write_edge", {31'b0, tx}, 32'h1);
      check("t1_busy_rise", {31'b0, busy}, 32'h1);
      rd(BASE + 4, d);
      check("t1_status", d, 32'h0000_0101);
      rd(BASE + 5, d);
      check("t1_status_lowbits", d, 32'h0000_0101);
      rd(BASE, d);
      check("t1_txdata_read", d, 32'h0);
      wait_idle(100, drop);
      check("t1_busy_drop", drop, n0 + 41);
      check("t1_start_cycle", (start_q.size() > 0) ? start_q[0] : -1, n0 + 1);
      rd(BASE + 4, d);
      check("t1_status_after", d, 32'h0);
      start_q.delete();

      // Back-to-back frames
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'h3C);
      put(8'hA5);
      put(8'h3C);
      put_end();
      n0 = cyc - 1;
      rd(BASE + 4, d);
      check("t2_status_count1", d, 32'h0000_0101);
      wait_idle(200, drop);
      check("t2_busy_drop", drop, n0 + 81);
      check("t2_gap", (start_q.size() == 2) ? start_q[1] - start_q[0] : -1, 40);
      start_q.delete();

      // Overflow with depth 4
      f0 = n_frames;
      for (int i = 1; i <= 5; i++) exp_q.push_back(8'(i));
      for (int i = 1; i <= 6; i++) put(8'(i));
      put_end();
      n0 = cyc - 5;
      rd(BASE + 4, d);
      check("t3_status_full_ovf", d, 32'h0000_0407);
      bus_write(BASE + 4, 32'h4);
      rd(BASE + 4, d);
      check("t3_ovf_cleared", d, 32'h0000_0403);
      wait_idle(400, drop);
      check("t3_busy_drop", drop, n0 + 201);
      check("t3_frames", n_frames - f0, 5);
      start_q.delete();

      // Reset mid-DATA with 3 bytes queued
      f0 = n_frames;
      for (int i = 0; i < 4; i++) put(8'hF0 + 8'(i));
      put_end();
      repeat (14) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("t4_tx_after_rst", {31'b0, tx}, 32'h1);
      check("t4_busy_after_rst", {31'b0, busy}, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      rd(BASE + 4, d);
      check("t4_status_after_rst", d, 32'h0);
      repeat (100) @(posedge clk);
      #1 check("t4_no_frames", n_frames - f0, 0);
      check("t4_still_idle", {31'b0, busy}, 32'h0);
      start_q.delete();

`ifdef MMIO_UART_TX_STATS_EN
      bus_write(BASE + 8, 32'h0);
      for (int i = 1; i <= 5; i++) exp_q.push_back(8'h10 + 8'(i));
      for (int i = 1; i <= 7; i++) put(8'h10 + 8'(i));
      put_end();
      n0 = cyc - 6;
      wait_idle(400, drop);
      check("t5_busy_drop", drop, n0 + 201);
      rd(BASE + 8, d);
      check("t5_sent", d, 32'd5);
      rd(BASE + 12, d);
      check("t5_dropped", d, 32'd2);
      bus_write(BASE + 8, 32'h0);
      rd(BASE + 8, d);
      check("t5_sent_clr", d, 32'h0);
      rd(BASE + 12, d);
      check("t5_dropped_clr", d, 32'h0);
`else
      bus_write(BASE + 8, 32'hFFFF_FFFF);
      rd(BASE + 8, d);
      check("t5_reg8_zero", d, 32'h0);
      rd(BASE + 12, d);
      check("t5_regc_zero", d, 32'h0);
      check("t5_idle_after_w8", {31'b0, busy}, 32'h0);
`endif

      check("exp_queue_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
